// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory arbiter: read-return
//                owner encoding and the default DMA starvation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_PIPE_RD = 2'd1,
        OWN_DMA_RD  = 2'd2
    } owner_t;

    localparam int          c_starve_limit_def = 8;
    localparam int          c_cnt_w            = 4;
    localparam logic [3:0]  c_cnt_max          = 4'd15;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Single-port data RAM arbiter between the MEM pipeline stage
//                and a DMA/debug loader. Pipeline has priority; optional
//                starvation relief enabled by defining DMEM_ARB_FAIRNESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = c_starve_limit_def,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    // pipeline MEM stage
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [AW-1:0] p_wdata,
    output logic          p_stall,
    output logic [AW-1:0] p_rdata,
    // DMA / debug loader
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [AW-1:0] d_rdata,
    // RAM
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata
);

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
            $error("dmem_arbiter: STARVE_LIMIT must be within 1..15");
        end
    endgenerate

    logic   w_force;
    logic   w_dma_gnt;
    logic   w_pipe_gnt;
    owner_t r_owner;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_conflict_cnt;

    assign w_force = d_req && (r_conflict_cnt >= c_limit);

    // Counts consecutive cycles the pipeline beat a waiting DMA request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_dma_gnt || !d_req) begin
            r_conflict_cnt <= '0;
        end else if (p_req && (r_conflict_cnt != c_cnt_max)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_dma_gnt  = d_req && (!p_req || w_force);
    assign w_pipe_gnt = p_req && !w_dma_gnt;

    assign p_stall = p_req && w_dma_gnt;
    assign d_gnt   = w_dma_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = p_addr;
        mem_wdata = p_wdata;
        if (w_dma_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_pipe_gnt) begin
            mem_we    = p_we;
        end
    end

    // Remembers who issued last cycle's read so the RAM data can be routed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else if (w_pipe_gnt && !p_we) begin
            r_owner <= OWN_PIPE_RD;
        end else if (w_dma_gnt && !d_we) begin
            r_owner <= OWN_DMA_RD;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    assign d_rvalid = (r_owner == OWN_DMA_RD);
    assign d_rdata  = mem_rdata;
    assign p_rdata  = mem_rdata;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a behavioural RAM
//                and arbitration model. Honours DMEM_ARB_FAIRNESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, d_req, d_we;
    logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
    logic        p_stall, d_gnt, d_rvalid, mem_we;
    logic [31:0] p_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:255];

    int n_chk = 0;
    int n_err = 0;

    // model state
    logic [31:0] m_mem [0:255];
    int          m_prev;      // 0 none, 1 pipe read, 2 dma read
    logic [31:0] m_exp;
    int          m_streak;
    logic        last_stall, last_gnt, last_we;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model.
    task automatic cycle(input logic rs,
                         input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        logic e_force, e_dg, e_pg, e_stall, e_we;
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        rst = rs; p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        e_force = FAIR && dr && (m_streak >= LIMIT);
        e_dg    = dr && (!pr || e_force);
        e_pg    = pr && !e_dg;
        e_stall = pr && e_dg;
        e_we    = e_pg ? pw : (e_dg ? dw : 1'b0);
        e_addr  = e_dg ? da : pa;
        e_wd    = e_dg ? dd : pd;
        check("p_stall", {31'd0, p_stall}, {31'd0, e_stall});
        check("d_gnt", {31'd0, d_gnt}, {31'd0, e_dg});
        check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        if (e_pg || e_dg) check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wd);
        check("d_rvalid", {31'd0, d_rvalid}, {31'd0, (m_prev == 2)});
        if (m_prev == 1) check("p_rdata", p_rdata, m_exp);
        if (m_prev == 2) check("d_rdata", d_rdata, m_exp);
        last_stall = p_stall; last_gnt = d_gnt; last_we = mem_we;
        @(posedge clk);
        if (e_pg && !pw) begin m_prev = 1; m_exp = m_mem[pa[7:0]]; end
        else if (e_dg && !dw) begin m_prev = 2; m_exp = m_mem[da[7:0]]; end
        else m_prev = 0;
        if (e_we) m_mem[e_addr[7:0]] = e_wd;
        if (e_dg || !dr) m_streak = 0;
        else if (pr) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
        if (rs) begin m_prev = 0; m_streak = 0; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic pr, pw; logic [31:0] pa, pd;
        logic dr, dw; logic [31:0] da, dd;
        logic e_stall, e_gnt, e_we;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vt [7];
        logic dr, dw; logic [31:0] da, dd;
        for (int i = 0; i < 256; i++) begin ram[i] = '0; m_mem[i] = '0; end
        mem_rdata = '0; m_prev = 0; m_exp = '0; m_streak = 0;
        rst = 1'b1; p_req = 0; p_we = 0; d_req = 0; d_we = 0;
        p_addr = '0; p_wdata = '0; d_addr = '0; d_wdata = '0;

        // reset state
        #2;
        check("reset_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("reset_stall", {31'd0, p_stall}, 32'd0);
        cycle(1'b1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(2);

        // grant table
        vt[0] = '{1,0,32'h04,32'h0,        0,0,32'h0, 32'h0,        0,0,0};
        vt[1] = '{1,1,32'h08,32'hA5A5A5A5, 0,0,32'h0, 32'h0,        0,0,1};
        vt[2] = '{0,0,32'h0, 32'h0,        1,1,32'h0C,32'h0BADF00D, 0,1,1};
        vt[3] = '{0,0,32'h0, 32'h0,        1,0,32'h0C,32'h0,        0,1,0};
        vt[4] = '{1,1,32'h30,32'h11111111, 1,1,32'h34,32'h22222222, 0,0,1};
        vt[5] = '{1,0,32'h30,32'h0,        1,1,32'h34,32'h22222222, 0,0,0};
        vt[6] = '{0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,0};
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, vt[i].pr, vt[i].pw, vt[i].pa, vt[i].pd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
            check($sformatf("tbl%0d_stall", i), {31'd0, last_stall}, {31'd0, vt[i].e_stall});
            check($sformatf("tbl%0d_gnt", i), {31'd0, last_gnt}, {31'd0, vt[i].e_gnt});
            check($sformatf("tbl%0d_we", i), {31'd0, last_we}, {31'd0, vt[i].e_we});
        end

        // pipeline write then read back
        cycle(1'b0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        check("p_wr_we", {31'd0, last_we}, 32'd1);
        cycle(1'b0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        check("p_rd_stall", {31'd0, last_stall}, 32'd0);
        cycle(1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("p_rd_data", p_rdata, 32'hDEADBEEF);

        // DMA write then read back
        cycle(1'b0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678);
        check("d_wr_gnt", {31'd0, last_gnt}, 32'd1);
        cycle(1'b0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
        check("d_rd_gnt", {31'd0, last_gnt}, 32'd1);
        cycle(1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("d_rd_valid", {31'd0, d_rvalid}, 32'd1);
        check("d_rd_data", d_rdata, 32'h12345678);

        // sustained conflict: forced grants at cycles 8 and 17 when fair
        idle(1);
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0, 1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
            check($sformatf("starve_gnt_c%0d", c), {31'd0, last_gnt},
                  {31'd0, FAIR && (c == 8 || c == 17)});
            check($sformatf("starve_stall_c%0d", c), {31'd0, last_stall},
                  {31'd0, FAIR && (c == 8 || c == 17)});
        end

        // d_req gap after five conflicts restarts the count
        idle(1);
        for (int c = 0; c < 5; c++) cycle(1'b0, 1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
        cycle(1'b0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h44, 32'h0);
        for (int c = 0; c < 9; c++) begin
            cycle(1'b0, 1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
            check($sformatf("gap_gnt_c%0d", c), {31'd0, last_gnt}, {31'd0, FAIR && (c == 8)});
        end
        idle(1);

        // asynchronous reset kills a pending DMA read return
        cycle(1'b0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
        @(negedge clk);
        p_req = 0; d_req = 0; p_we = 0; d_we = 0;
        #1;
        check("rst_pre_rvalid", {31'd0, d_rvalid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_rvalid", {31'd0, d_rvalid}, 32'd0);
        m_prev = 0; m_streak = 0;
        cycle(1'b1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
            check($sformatf("rst_no_pulse_c%0d", c), {31'd0, d_rvalid}, 32'd0);
        end

        // randomized traffic; DMA holds its request until granted
        dr = 0; dw = 0; da = '0; dd = '0;
        for (int i = 0; i < 400; i++) begin
            logic pr, pw;
            pr = ($urandom_range(0, 9) < 6);
            pw = $urandom_range(0, 1);
            if (!dr && ($urandom_range(0, 1) == 1)) begin
                dr = 1; dw = $urandom_range(0, 1); da = $urandom; dd = $urandom;
            end
            cycle(1'b0, pr, pw, $urandom, $urandom, dr, dw, da, dd);
            if (last_gnt) dr = 0;
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8, the number of consecutive pipeline-won conflict cycles before a forced DMA grant (range 1..15).
REQ-002 The block SHALL have parameter AW, default 32, the address and data width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 p_req  in  1  MEM-stage access request (load or store) this cycle.
REQ-006 p_we  in  1  MEM-stage store enable.
REQ-007 p_addr, p_wdata  in  AW  MEM-stage address and store data.
REQ-008 p_stall  out  1  MEM-stage access not taken this cycle; the pipeline holds.
REQ-009 p_rdata  out  AW  load data, valid the cycle after a granted pipeline read.
REQ-010 d_req, d_we  in  1  DMA/debug loader request and write enable.
REQ-011 d_addr, d_wdata  in  AW  DMA address and write data.
REQ-012 d_gnt  out  1  DMA access taken this cycle.
REQ-013 d_rvalid  out  1  one-cycle pulse, the cycle after a granted DMA read.
REQ-014 d_rdata  out  AW  DMA read data, valid while d_rvalid=1.
REQ-015 mem_we  out  1  RAM write enable.
REQ-016 mem_addr, mem_wdata  out  AW  RAM address and write data.
REQ-017 mem_rdata  in  AW  RAM read data, one cycle after the address (registered read).

Function
REQ-018 The grant SHALL be combinational each cycle; pipeline has priority: p_req=1 grants the pipeline, else d_req=1 grants DMA, else idle.
REQ-019 mem_we/mem_addr/mem_wdata SHALL mux from the granted port; mem_we SHALL be 0 when idle or on a read grant.
REQ-020 p_stall=1 SHALL hold only when p_req=1 and DMA is granted that cycle; d_gnt=1 only when DMA is granted.
REQ-021 A registered 2-bit owner (NONE, PIPE_RD, DMA_RD) SHALL record each cycle's read grant for return routing; writes record NONE.
REQ-022 d_rvalid SHALL equal (owner==DMA_RD); d_rdata and p_rdata SHALL both be driven from mem_rdata.
REQ-023 A 4-bit conflict counter SHALL increment in cycles with p_req=1 and d_req=1 where the pipeline wins, saturating at 15.
REQ-024 The counter SHALL clear on any DMA grant and in any cycle where d_req=0.
REQ-025 Accepting a request SHALL take exactly one cycle; back-to-back grants to either port in consecutive cycles SHALL be allowed.
REQ-026 A DMA request SHALL hold address, data and we stable until d_gnt; a DMA write becomes visible to a read granted the next cycle.

Reset
REQ-027 On rst, owner=NONE, counter=0, d_rvalid=0 immediately; p_stall and d_gnt follow REQ-018/020 combinationally.
REQ-028 A read granted in the cycle rst asserts SHALL produce no d_rvalid pulse after reset release.

Configuration
REQ-029 With DMEM_ARB_FAIRNESS_EN defined, when counter>=STARVE_LIMIT and d_req=1, DMA SHALL be granted and p_stall=1 for that cycle.
REQ-030 Without DMEM_ARB_FAIRNESS_EN, the pipeline SHALL be granted strictly (REQ-018); the counter SHALL be absent and DMA may starve.

Structure
REQ-031 The owner encoding and the default STARVE_LIMIT SHALL live in the shared package dmem_pkg.
REQ-032 The block SHALL be a single module with no sub-module; the RAM stays outside.

Verification
REQ-033 The bench SHALL drive p_req=1, p_we=1, addr 0x10, data 0xDEADBEEF, then a p_req read of 0x10 -> mem_we=1 in cycle 0, p_stall=0 throughout, p_rdata=0xDEADBEEF in cycle 2.
REQ-034 The bench SHALL drive a DMA-only write of 0x20=0x12345678 followed by a DMA read -> d_gnt=1 both cycles, d_rvalid=1 one cycle after the read, d_rdata=0x12345678.
REQ-035 The bench SHALL drive p_req and d_req held high for 20 cycles with FAIRNESS on and STARVE_LIMIT=8 -> d_gnt=1 in cycle 8 with p_stall=1, then counter=0 and a repeat in cycle 17.
REQ-036 The bench SHALL repeat REQ-035 with FAIRNESS off -> d_gnt=0 and p_stall=0 in all 20 cycles.
REQ-037 The bench SHALL drive a DMA read granted in cycle N with rst asserted in N+1 mid-cycle -> d_rvalid=0 immediately and no later pulse.
REQ-038 The bench SHALL drive d_req dropped for one cycle after counter=5 -> counter=0 and no forced grant until 8 further conflict cycles.
